vec_len_sequencer: RTL and testbench

- Controller that computes res = sqrt(a1*b1 + a2*b2 + a3*b3) in IEEE-754 single precision.
- It time-shares one multiplier instance and one two-input adder instance, then sequences one sqrt instance. These replace the three parallel multipliers and the add3 block.
- All transfers use the stb/ack handshake. There are no derived clocks and no multi-edge always blocks.
- It sits between the sphere-collision top level and the FP units. It exposes a start/done interface with a busy flag and an error flag.

---
 rtl/vec_len_pkg.sv | 20 ++
 rtl/stb_ack_port.sv | 63 ++++++
 rtl/vec_len_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_vec_len_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_len_pkg.sv
// Shared constants for the vector-length sequencer: FSM state encodings,
// floating-point word width and a few handy IEEE-754 single-precision values.
package vec_len_pkg;

    localparam int unsigned FP_W = 32;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] MUL_ISSUE  = 3'd1;
    localparam logic [2:0] MUL_WAIT   = 3'd2;
    localparam logic [2:0] ADD_ISSUE  = 3'd3;
    localparam logic [2:0] ADD_WAIT   = 3'd4;
    localparam logic [2:0] SQRT_START = 3'd5;
    localparam logic [2:0] SQRT_WAIT  = 3'd6;
    localparam logic [2:0] DONE       = 3'd7;

    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F800000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h40000000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h40400000;

endpackage

// File: rtl/stb_ack_port.sv
// One stb/ack client port toward a two-operand FP unit: holds the operands and
// input strobe until acked, and acknowledges the result strobe while waiting.
module stb_ack_port
    import vec_len_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            abort_i,
    input  logic [FP_W-1:0] ld_a_i,
    input  logic [FP_W-1:0] ld_b_i,
    input  logic            wait_i,
    input  logic            in_ack_i,
    input  logic            z_stb_i,
    output logic            in_stb_o,
    output logic [FP_W-1:0] a_o,
    output logic [FP_W-1:0] b_o,
    output logic            z_ack_o,
    output logic            in_done_c,
    output logic            z_done_c
);

    logic            in_stb_q, in_stb_d;
    logic [FP_W-1:0] a_q, a_d;
    logic [FP_W-1:0] b_q, b_d;

    assign in_done_c = in_stb_q & in_ack_i;
    assign z_ack_o   = wait_i & z_stb_i;
    assign z_done_c  = z_ack_o;

    // Strobe rises with a load and falls after the ack cycle or on abort.
    always_comb begin
        in_stb_d = in_stb_q;
        a_d      = a_q;
        b_d      = b_q;
        if (abort_i) begin
            in_stb_d = 1'b0;
        end else if (load_i) begin
            in_stb_d = 1'b1;
            a_d      = ld_a_i;
            b_d      = ld_b_i;
        end else if (in_done_c) begin
            in_stb_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_stb_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            in_stb_q <= in_stb_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign in_stb_o = in_stb_q;
    assign a_o      = a_q;
    assign b_o      = b_q;

endmodule

// File: rtl/vec_len_sequencer.sv
// Sequences sqrt(a1*b1 + a2*b2 + a3*b3) over one shared multiplier, one shared
// adder and one sqrt unit, with a per-handshake timeout that aborts with err.
module vec_len_sequencer
    import vec_len_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TW      = 10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [FP_W-1:0] a1,
    input  logic [FP_W-1:0] a2,
    input  logic [FP_W-1:0] a3,
    input  logic [FP_W-1:0] b1,
    input  logic [FP_W-1:0] b2,
    input  logic [FP_W-1:0] b3,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [FP_W-1:0] res,
    output logic [FP_W-1:0] mul_a,
    output logic [FP_W-1:0] mul_b,
    output logic            mul_in_stb,
    input  logic            mul_in_ack,
    input  logic [FP_W-1:0] mul_z,
    input  logic            mul_z_stb,
    output logic            mul_z_ack,
    output logic [FP_W-1:0] add_a,
    output logic [FP_W-1:0] add_b,
    output logic            add_in_stb,
    input  logic            add_in_ack,
    input  logic [FP_W-1:0] add_z,
    input  logic            add_z_stb,
    output logic            add_z_ack,
    output logic [FP_W-1:0] sqrt_n,
    output logic            sqrt_rst,
    input  logic [FP_W-1:0] sqrt_root,
    input  logic            sqrt_rdy
);

    logic [2:0]           state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sqrt_rst_q, sqrt_rst_d;
    logic [FP_W-1:0]      res_q, res_d;
    logic [FP_W-1:0]      sum_q, sum_d;
    logic [2:0][FP_W-1:0] opa_q, opa_d;
    logic [2:0][FP_W-1:0] opb_q, opb_d;
    logic [2:0][FP_W-1:0] p_q, p_d;

    logic            mul_load_c, add_load_c, abort_c, tmo_hit_c, count_c;
    logic            mul_in_done_c, mul_z_done_c, add_in_done_c, add_z_done_c;
    logic [FP_W-1:0] mul_ld_a_c, mul_ld_b_c, add_ld_a_c, add_ld_b_c;

    stb_ack_port u_mul_port (
        .clk       (CLK),
        .rst       (RST),
        .load_i    (mul_load_c),
        .abort_i   (abort_c),
        .ld_a_i    (mul_ld_a_c),
        .ld_b_i    (mul_ld_b_c),
        .wait_i    (state_q == MUL_WAIT),
        .in_ack_i  (mul_in_ack),
        .z_stb_i   (mul_z_stb),
        .in_stb_o  (mul_in_stb),
        .a_o       (mul_a),
        .b_o       (mul_b),
        .z_ack_o   (mul_z_ack),
        .in_done_c (mul_in_done_c),
        .z_done_c  (mul_z_done_c)
    );

    stb_ack_port u_add_port (
        .clk       (CLK),
        .rst       (RST),
        .load_i    (add_load_c),
        .abort_i   (abort_c),
        .ld_a_i    (add_ld_a_c),
        .ld_b_i    (add_ld_b_c),
        .wait_i    (state_q == ADD_WAIT),
        .in_ack_i  (add_in_ack),
        .z_stb_i   (add_z_stb),
        .in_stb_o  (add_in_stb),
        .a_o       (add_a),
        .b_o       (add_b),
        .z_ack_o   (add_z_ack),
        .in_done_c (add_in_done_c),
        .z_done_c  (add_z_done_c)
    );

    assign tmo_hit_c = (tmo_q == TW'(TIMEOUT - 1));
    assign count_c   = (state_q == MUL_ISSUE) || (state_q == MUL_WAIT) ||
                       (state_q == ADD_ISSUE) || (state_q == ADD_WAIT) ||
                       (state_q == SQRT_WAIT);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        res_d      = res_q;
        sum_d      = sum_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        p_d        = p_q;
        mul_load_c = 1'b0;
        add_load_c = 1'b0;
        abort_c    = 1'b0;
        mul_ld_a_c = '0;
        mul_ld_b_c = '0;
        add_ld_a_c = '0;
        add_ld_b_c = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d      = {a3, a2, a1};
                    opb_d      = {b3, b2, b1};
                    err_d      = 1'b0;
                    op_d       = 2'd0;
                    mul_load_c = 1'b1;
                    mul_ld_a_c = a1;
                    mul_ld_b_c = b1;
                    state_d    = MUL_ISSUE;
                end
            end
            MUL_ISSUE: begin
                if (mul_in_done_c) state_d = MUL_WAIT;
                else if (tmo_hit_c) abort_c = 1'b1;
            end
            MUL_WAIT: begin
                if (mul_z_done_c) begin
                    case (op_q)
                        2'd0:    p_d[0] = mul_z;
                        2'd1:    p_d[1] = mul_z;
                        default: p_d[2] = mul_z;
                    endcase
                    if (op_q == 2'd2) begin
                        op_d       = 2'd0;
                        add_load_c = 1'b1;
                        add_ld_a_c = p_q[0];
                        add_ld_b_c = p_q[1];
                        state_d    = ADD_ISSUE;
                    end else begin
                        op_d       = op_q + 2'd1;
                        mul_load_c = 1'b1;
                        mul_ld_a_c = (op_q == 2'd0) ? opa_q[1] : opa_q[2];
                        mul_ld_b_c = (op_q == 2'd0) ? opb_q[1] : opb_q[2];
                        state_d    = MUL_ISSUE;
                    end
                end else if (tmo_hit_c) begin
                    abort_c = 1'b1;
                end
            end
            ADD_ISSUE: begin
                if (add_in_done_c) state_d = ADD_WAIT;
                else if (tmo_hit_c) abort_c = 1'b1;
            end
            ADD_WAIT: begin
                if (add_z_done_c) begin
                    sum_d = add_z;
                    if (op_q == 2'd1) begin
                        op_d    = 2'd0;
                        state_d = SQRT_START;
                    end else begin
                        // Second add chains the fresh partial sum straight from the adder.
                        op_d       = 2'd1;
                        add_load_c = 1'b1;
                        add_ld_a_c = add_z;
                        add_ld_b_c = p_q[2];
                        state_d    = ADD_ISSUE;
                    end
                end else if (tmo_hit_c) begin
                    abort_c = 1'b1;
                end
            end
            SQRT_START: state_d = SQRT_WAIT;
            SQRT_WAIT: begin
                if (sqrt_rdy) begin
                    res_d   = sqrt_root;
                    state_d = DONE;
                end else if (tmo_hit_c) begin
                    abort_c = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_c) begin
            state_d = IDLE;
            op_d    = 2'd0;
            err_d   = 1'b1;
        end

        if (state_d != state_q) tmo_d = '0;
        else if (count_c)       tmo_d = tmo_q + TW'(1);

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        sqrt_rst_d = !((state_d == SQRT_START) || (state_d == SQRT_WAIT));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sqrt_rst_q <= 1'b1;
            res_q      <= '0;
            sum_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            p_q        <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sqrt_rst_q <= sqrt_rst_d;
            res_q      <= res_d;
            sum_q      <= sum_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            p_q        <= p_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign res      = res_q;
    assign sqrt_rst = sqrt_rst_q;
    assign sqrt_n   = sum_q;

endmodule

// File: tb/tb_vec_len_sequencer.sv
// Directed bench for vec_len_sequencer with behavioural mul/add/sqrt units
// (integer-valued floats only) and a result scoreboard keyed on done pulses.
module tb_vec_len_sequencer;
    import vec_len_pkg::*;

    localparam logic [31:0] FP_THREE_I = 32'h40400000;
    localparam logic [31:0] FP_FOUR    = 32'h40800000;
    localparam logic [31:0] FP_FIVE    = 32'h40A00000;

    logic        CLK = 1'b0;
    logic        RST, start;
    logic [31:0] a1, a2, a3, b1, b2, b3;
    logic        busy, done, err;
    logic [31:0] res;
    logic [31:0] mul_a, mul_b, mul_z, add_a, add_b, add_z, sqrt_n, sqrt_root;
    logic        mul_in_stb, mul_in_ack, mul_z_stb, mul_z_ack;
    logic        add_in_stb, add_in_ack, add_z_stb, add_z_ack;
    logic        sqrt_rst, sqrt_rdy;

    logic        rand_mode, mul_hang, chk_stab;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    vec_len_sequencer #(.TIMEOUT(16), .TW(5)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
        .busy(busy), .done(done), .err(err), .res(res),
        .mul_a(mul_a), .mul_b(mul_b), .mul_in_stb(mul_in_stb), .mul_in_ack(mul_in_ack),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .add_a(add_a), .add_b(add_b), .add_in_stb(add_in_stb), .add_in_ack(add_in_ack),
        .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .sqrt_n(sqrt_n), .sqrt_rst(sqrt_rst), .sqrt_root(sqrt_root), .sqrt_rdy(sqrt_rdy)
    );

    function automatic int unsigned f2i(input logic [31:0] f);
        int unsigned m, sh;
        if (f[30:0] == 31'd0) return 0;
        m  = {8'd0, 1'b1, f[22:0]};
        sh = 32'd150 - {24'd0, f[30:23]};
        return m >> sh;
    endfunction

    function automatic logic [31:0] i2f(input int unsigned n);
        int unsigned e;
        logic [31:0] m;
        if (n == 0) return 32'd0;
        e = 0;
        for (int i = 0; i < 24; i++) if (n[i]) e = 32'(i);
        m = n << (23 - e);
        return {1'b0, 8'(e + 32'd127), m[22:0]};
    endfunction

    function automatic int unsigned isqrt(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        chk("done_within_bound", 32'(done), 32'd1);
    endtask

    task automatic set_ops(input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] x3);
        a1 = x1; a2 = x2; a3 = x3;
        b1 = x1; b2 = x2; b3 = x3;
    endtask

    // Multiplier model: ack after m_dly stb cycles, result m_zc cycles later.
    int   m_cnt, m_dly, m_zc;
    logic m_pend;
    assign mul_in_ack = mul_in_stb && !mul_hang && (m_cnt >= m_dly);
    always @(posedge CLK) begin : mul_model
        int zd;
        if (RST) begin
            m_cnt <= 0; m_dly <= 0; m_zc <= 0; m_pend <= 1'b0;
            mul_z_stb <= 1'b0; mul_z <= '0;
        end else begin
            if (mul_in_stb && mul_in_ack) begin
                zd = rand_mode ? int'($urandom_range(0, 12)) : 0;
                m_cnt <= 0;
                m_dly <= rand_mode ? int'($urandom_range(0, 12)) : 0;
                mul_z <= i2f(f2i(mul_a) * f2i(mul_b));
                if (zd == 0) mul_z_stb <= 1'b1;
                else begin m_zc <= zd; m_pend <= 1'b1; end
            end else if (mul_in_stb) begin
                m_cnt <= m_cnt + 1;
            end else begin
                m_cnt <= 0;
                m_dly <= rand_mode ? int'($urandom_range(0, 12)) : 0;
            end
            if (m_pend) begin
                m_zc <= m_zc - 1;
                if (m_zc == 1) begin mul_z_stb <= 1'b1; m_pend <= 1'b0; end
            end
            if (mul_z_stb && mul_z_ack) mul_z_stb <= 1'b0;
        end
    end

    int   s_cnt, s_dly, s_zc;
    logic s_pend;
    assign add_in_ack = add_in_stb && (s_cnt >= s_dly);
    always @(posedge CLK) begin : add_model
        int zd;
        if (RST) begin
            s_cnt <= 0; s_dly <= 0; s_zc <= 0; s_pend <= 1'b0;
            add_z_stb <= 1'b0; add_z <= '0;
        end else begin
            if (add_in_stb && add_in_ack) begin
                zd = rand_mode ? int'($urandom_range(0, 12)) : 0;
                s_cnt <= 0;
                s_dly <= rand_mode ? int'($urandom_range(0, 12)) : 0;
                add_z <= i2f(f2i(add_a) + f2i(add_b));
                if (zd == 0) add_z_stb <= 1'b1;
                else begin s_zc <= zd; s_pend <= 1'b1; end
            end else if (add_in_stb) begin
                s_cnt <= s_cnt + 1;
            end else begin
                s_cnt <= 0;
                s_dly <= rand_mode ? int'($urandom_range(0, 12)) : 0;
            end
            if (s_pend) begin
                s_zc <= s_zc - 1;
                if (s_zc == 1) begin add_z_stb <= 1'b1; s_pend <= 1'b0; end
            end
            if (add_z_stb && add_z_ack) add_z_stb <= 1'b0;
        end
    end

    always @(posedge CLK) begin
        sqrt_rdy  <= !RST && !sqrt_rst;
        sqrt_root <= i2f(isqrt(f2i(sqrt_n)));
    end

    // Scoreboard and handshake-stability monitor, sampled mid-cycle.
    logic        m_hold = 1'b0, s_hold = 1'b0;
    logic [31:0] m_pa, m_pb, s_pa, s_pb;
    always @(negedge CLK) begin
        if (!RST && done === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
            else chk("res", res, exp_q.pop_front());
        end
        if (chk_stab && m_hold) begin
            chk("mul_stb_hold", 32'(mul_in_stb), 32'd1);
            chk("mul_a_hold", mul_a, m_pa);
            chk("mul_b_hold", mul_b, m_pb);
        end
        if (chk_stab && s_hold) begin
            chk("add_stb_hold", 32'(add_in_stb), 32'd1);
            chk("add_a_hold", add_a, s_pa);
            chk("add_b_hold", add_b, s_pb);
        end
        if (chk_stab && (mul_z_stb || mul_z_ack)) chk("mul_z_ack", 32'(mul_z_ack), 32'(mul_z_stb));
        if (chk_stab && (add_z_stb || add_z_ack)) chk("add_z_ack", 32'(add_z_ack), 32'(add_z_stb));
        m_hold = mul_in_stb && !mul_in_ack; m_pa = mul_a; m_pb = mul_b;
        s_hold = add_in_stb && !add_in_ack; s_pa = add_a; s_pb = add_b;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},     32'(busy),       32'd0);
        chk({tag, "_done"},     32'(done),       32'd0);
        chk({tag, "_err"},      32'(err),        32'd0);
        chk({tag, "_res"},      res,             32'd0);
        chk({tag, "_mul_stb"},  32'(mul_in_stb), 32'd0);
        chk({tag, "_add_stb"},  32'(add_in_stb), 32'd0);
        chk({tag, "_mul_zack"}, 32'(mul_z_ack),  32'd0);
        chk({tag, "_add_zack"}, 32'(add_z_ack),  32'd0);
        chk({tag, "_sqrt_rst"}, 32'(sqrt_rst),   32'd1);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0;
        rand_mode = 1'b0; mul_hang = 1'b0; chk_stab = 1'b0;
        set_ops(32'd0, 32'd0, 32'd0);
        tick(3);
        chk_reset_vals("reset");
        RST = 1'b0;
        tick(1);

        // Zero-latency units: done exactly 13 cycles after acceptance.
        set_ops(FP_ONE, FP_TWO, FP_TWO);
        start = 1'b1;
        exp_q.push_back(FP_THREE);
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            if (k == 1) start = 1'b0;
            chk("lat_busy", 32'(busy), 32'(k <= 13));
            chk("lat_done", 32'(done), 32'(k == 13));
            if (k == 1) chk("lat_mul_a_op0", mul_a, FP_ONE);
            if (k == 3) chk("lat_mul_a_op1", mul_a, FP_TWO);
            if (k == 13) chk("lat_err", 32'(err), 32'd0);
        end

        // Random unit delays with handshake stability checks.
        rand_mode = 1'b1; chk_stab = 1'b1;
        set_ops(FP_THREE_I, FP_FOUR, 32'd0);
        start = 1'b1;
        exp_q.push_back(FP_FIVE);
        tick(1);
        start = 1'b0;
        wait_done();
        tick(2);
        chk_stab = 1'b0; rand_mode = 1'b0;
        tick(2);

        // start held high: exactly two ops, second uses operands present in IDLE.
        set_ops(FP_ONE, FP_TWO, FP_TWO);
        start = 1'b1;
        exp_q.push_back(FP_THREE);
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == 2) set_ops(FP_THREE_I, FP_FOUR, 32'd0);
            if (k == 14) exp_q.push_back(FP_FIVE);
            if (k == 15) start = 1'b0;
            chk("held_done", 32'(done), 32'((k == 13) || (k == 27)));
            chk("held_busy", 32'(busy), 32'((k <= 13) || (k >= 15 && k <= 27)));
        end

        // Multiplier never acks: timeout after 16 cycles, no done.
        mul_hang = 1'b1;
        set_ops(FP_ONE, FP_TWO, FP_TWO);
        start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            if (k == 1) start = 1'b0;
            if (k <= 16) begin
                chk("tmo_err_low", 32'(err), 32'd0);
                chk("tmo_stb_high", 32'(mul_in_stb), 32'd1);
            end
        end
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_mul_stb", 32'(mul_in_stb), 32'd0);
        chk("tmo_add_stb", 32'(add_in_stb), 32'd0);
        chk("tmo_sqrt_rst", 32'(sqrt_rst), 32'd1);
        chk("tmo_res_kept", res, FP_FIVE);
        mul_hang = 1'b0;
        start = 1'b1;
        exp_q.push_back(FP_THREE);
        tick(1);
        start = 1'b0;
        chk("tmo_err_cleared", 32'(err), 32'd0);
        wait_done();
        tick(2);

        // Reset in ADD_WAIT, then a clean operation.
        set_ops(FP_ONE, FP_TWO, FP_TWO);
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 1) start = 1'b0;
        end
        chk("rst_in_add_wait", 32'(add_z_ack), 32'd1);
        RST = 1'b1;
        tick(1);
        chk_reset_vals("midrst");
        RST = 1'b0;
        set_ops(FP_ONE, 32'd0, 32'd0);
        start = 1'b1;
        exp_q.push_back(FP_ONE);
        tick(1);
        start = 1'b0;
        wait_done();
        tick(3);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
